enc_bank: RTL and testbench
===========================

# enc_bank

Multi-channel quadrature rotary-encoder front end that generalises the single-encoder position counter. It sits between the Pmod encoder headers and the pixel/colour position registers consumed by the core. Each of `NUM_CH` channels synchronises and debounces its A/B/button pins, decodes full quadrature detents and maintains a bounded position counter. Counters wrap or saturate, use a configurable step, and can be cleared by the push-button.

## Interface
- `NUM_CH`, 3: number of encoder channels.
- `CNT_W`, 8: width of each position counter.
- `MAX`, 160: counter modulus; valid range is 0..MAX-1. Constraint: 2 ≤ MAX ≤ 2^CNT_W.
- `STEP_SHIFT`, 0: step per detent is 1<<STEP_SHIFT. Constraint: step < MAX.
- `WRAP`, 1: 1 = modular wrap, 0 = saturate at 0 / MAX-1.
- `INIT`, 0: reset and clear value. Constraint: INIT < MAX.
- `DEB_CYCLES`, 50000: consecutive equal samples required to accept a pin level. Minimum 2.
- `BTN_CLEAR`, 1: 1 = a debounced button press loads INIT.

- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `enc_a` in NUM_CH: raw encoder A pins, one per channel.
- `enc_b` in NUM_CH: raw encoder B pins.
- `enc_btn` in NUM_CH: raw push-button pins, active-high.
- `count` out NUM_CH*CNT_W: position counters; channel i occupies bits [i*CNT_W +: CNT_W].
- `changed` out NUM_CH: one-cycle pulse when channel i's count register is written with a new value.
- `dir` out NUM_CH: direction of the last accepted detent (1 = CW). Holds its value between detents.
- `btn_press` out NUM_CH: one-cycle pulse on each debounced button rising edge.

## Operation
- **Input conditioning.** Each raw pin passes through a 2-FF synchroniser, then a debouncer. The debouncer's stable output changes only after DEB_CYCLES consecutive samples differ from the current stable value. Any sample equal to the stable value resets the debounce counter.
- **Quadrature phase.** The phase is {A,B}, with idle = 11.
  - CW sequence: 11→01→00→10→11. CCW sequence is the reverse.
- **Sub-step accumulator.** Each channel has a 4-bit signed accumulator, `acc`.
  - Valid CW transition: acc += 1. Valid CCW transition: acc -= 1.
  - Illegal transition (both bits change at once): ignored; acc is unchanged.
- **Detent completion.** On entering phase 11:
  - acc == +4: CW detent.
  - acc == -4: CCW detent.
  - Any other value: no detent.
  - In every case acc clears to 0.
- **Increment (CW).** v' = v+step.
  - If v+step ≥ MAX: WRAP=1 gives v+step-MAX; WRAP=0 gives MAX-1.
- **Decrement (CCW).** v' = v-step.
  - If v < step: WRAP=1 gives v+MAX-step; WRAP=0 gives 0.
- **Arithmetic width.** Compute in CNT_W+1 bits so MAX = 2^CNT_W cannot overflow.
- **changed pulse.** Asserts only if v' ≠ v. A saturated detent pulses nothing.
- **dir update.** dir updates on every detent, including a saturated one.
- **Button.** A debounced rising edge of btn pulses `btn_press`. If BTN_CLEAR=1, it also loads INIT; `changed` pulses if the old value ≠ INIT.
- **Simultaneous detent and clear.** In the same cycle, the clear wins and the detent is discarded.
- **Channel independence.** Channels share no state; simultaneous events on different channels are all applied.

## Timing
- Reset values:
  - count = INIT on every channel.
  - changed = 0, btn_press = 0, dir = 0.
  - Phase registers = 11, acc = 0, debounced outputs = 1/1/0 (A/B/btn), debounce counters = 0.
- Latency L = DEB_CYCLES+3 clocks. L runs from the first clock edge that samples the final raw edge to the cycle in which `count` and `changed` show the update: 2 synchroniser cycles + DEB_CYCLES + 1 register cycle.
- `changed` and `btn_press` are registered. They are high for exactly one cycle, aligned with the new `count`.
- Reset mid-detent discards partial progress. After release, rotation from an intermediate phase cannot produce a detent until the phase returns to 11.

## Structure
- Shared package `enc_pkg`:
  - Phase constants PH_IDLE=2'b11, PH_01, PH_00, PH_10.
  - Function `quad_delta(prev,cur)` returning signed -1/0/+1.
  - Step/bound helper functions.
- Sub-module `enc_channel`: synchroniser, three debouncers, decoder and counter for one channel. It receives all parameters.
- `enc_bank` instantiates `NUM_CH` copies of `enc_channel` in a generate loop and packs their outputs.

## Test plan
Sim configuration: NUM_CH=3, MAX=160, DEB_CYCLES=4, WRAP=1, STEP_SHIFT=0, unless stated otherwise.
- **Reset:** assert rst low mid-traffic → count=0 on all channels; changed, btn_press and dir are 0. Release, hold pins idle 100 cycles → no pulses.
- **CW detent:** one clean CW detent on ch0 (each phase held 10 cycles) → count0=1 exactly L=7 cycles after the last edge, changed=3'b001 for one cycle, dir[0]=1; ch1 and ch2 unchanged.
- **Wrap and saturate:** ch1 at 0, one CCW detent → 159. Separate instance with WRAP=0: CCW at 0 → stays 0 with no changed pulse. CW from 159 → stays 159.
- **Bounce and illegal moves:** a 2-cycle glitch on A, then 11→00 direct jumps → count unchanged and no pulses. Partial 11→01→11 → no detent.
- **Step wrap:** MAX=256, CNT_W=8, STEP_SHIFT=1, count=254, one CW detent → count=0 and changed pulses.
- **Button:** ch2 at 37, button pressed with its debounced edge landing in the same cycle as a CW detent → count2=INIT=0, btn_press[2] and changed[2] pulse once each. Reset asserted after two CW phases, then the rotation completed → no increment.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder bank: phase codes, the
// transition decoder and the bounded step arithmetic used by each channel.
package enc_pkg;

    localparam logic [1:0] PH_IDLE = 2'b11;
    localparam logic [1:0] PH_01   = 2'b01;
    localparam logic [1:0] PH_00   = 2'b00;
    localparam logic [1:0] PH_10   = 2'b10;

    // +1 for a clockwise neighbour step, -1 for counter-clockwise, 0 otherwise
    function automatic logic signed [1:0] quad_delta(input logic [1:0] prev, input logic [1:0] cur);
        logic signed [1:0] d;
        d = 2'sd0;
        case ({prev, cur})
            {PH_IDLE, PH_01}, {PH_01, PH_00}, {PH_00, PH_10}, {PH_10, PH_IDLE}: d = 2'sd1;
            {PH_01, PH_IDLE}, {PH_00, PH_01}, {PH_10, PH_00}, {PH_IDLE, PH_10}: d = -2'sd1;
            default: d = 2'sd0;
        endcase
        return d;
    endfunction

    // Wide integer arithmetic so a modulus of 2^CNT_W never overflows
    function automatic int step_inc(input int v, input int step, input int max, input int wrap);
        if (v + step >= max) begin
            return (wrap != 0) ? v + step - max : max - 1;
        end
        return v + step;
    endfunction

    function automatic int step_dec(input int v, input int step, input int max, input int wrap);
        if (v < step) begin
            return (wrap != 0) ? v + max - step : 0;
        end
        return v - step;
    endfunction

endpackage

// File: rtl/enc_channel.sv
// One encoder channel: pin synchronisers and debouncers, quadrature detent
// decoder and the bounded position counter with optional button clear.
module enc_channel
    import enc_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int MAX        = 160,
    parameter int STEP_SHIFT = 0,
    parameter int WRAP       = 1,
    parameter int INIT       = 0,
    parameter int DEB_CYCLES = 50000,
    parameter int BTN_CLEAR  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_btn,
    output logic [CNT_W-1:0] count,
    output logic             changed,
    output logic             dir,
    output logic             btn_press
);

    localparam int         DW      = $clog2(DEB_CYCLES + 1);
    localparam int         STEP    = 1 << STEP_SHIFT;
    localparam logic [2:0] PIN_RST = 3'b011;  // {btn, b, a} idle levels

    logic [2:0] raw;
    logic [2:0] stab;

    assign raw = {enc_btn, enc_b, enc_a};

    for (genvar gi = 0; gi < 3; gi++) begin : g_pin
        logic [1:0]    sync_q;
        logic          stab_q;
        logic [DW-1:0] deb_cnt_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q    <= {2{PIN_RST[gi]}};
                stab_q    <= PIN_RST[gi];
                deb_cnt_q <= '0;
            end else begin
                sync_q <= {sync_q[0], raw[gi]};
                if (sync_q[1] == stab_q) begin
                    deb_cnt_q <= '0;
                end else if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
                    stab_q    <= sync_q[1];
                    deb_cnt_q <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + 1'b1;
                end
            end
        end

        assign stab[gi] = stab_q;
    end

    logic [1:0]        phase;
    logic [1:0]        phase_q;
    logic signed [1:0] dlt;
    logic signed [3:0] acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              dir_q, dir_d;
    logic              changed_q, changed_d;
    logic              btn_press_q, btn_press_d;
    logic              btn_prev_q;
    logic              det_cw, det_ccw;

    assign phase = {stab[0], stab[1]};
    assign dlt   = quad_delta(phase_q, phase);

    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        dir_d       = dir_q;
        det_cw      = 1'b0;
        det_ccw     = 1'b0;
        btn_press_d = stab[2] & ~btn_prev_q;
        if (phase != phase_q) begin
            acc_d = acc_q + {{2{dlt[1]}}, dlt};
            if (phase == PH_IDLE) begin
                det_cw  = (acc_d == 4'sd4);
                det_ccw = (acc_d == -4'sd4);
                acc_d   = '0;
            end
        end
        if (det_cw) begin
            dir_d   = 1'b1;
            count_d = CNT_W'(step_inc(int'(count_q), STEP, MAX, WRAP));
        end else if (det_ccw) begin
            dir_d   = 1'b0;
            count_d = CNT_W'(step_dec(int'(count_q), STEP, MAX, WRAP));
        end
        // A clear in the same cycle discards the detent entirely, direction included
        if (btn_press_d && BTN_CLEAR != 0) begin
            count_d = CNT_W'(INIT);
            dir_d   = dir_q;
        end
        changed_d = (count_d != count_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q     <= PH_IDLE;
            acc_q       <= '0;
            count_q     <= CNT_W'(INIT);
            dir_q       <= 1'b0;
            changed_q   <= 1'b0;
            btn_press_q <= 1'b0;
            btn_prev_q  <= 1'b0;
        end else begin
            phase_q     <= phase;
            acc_q       <= acc_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            changed_q   <= changed_d;
            btn_press_q <= btn_press_d;
            btn_prev_q  <= stab[2];
        end
    end

    assign count     = count_q;
    assign changed   = changed_q;
    assign dir       = dir_q;
    assign btn_press = btn_press_q;

endmodule

// File: rtl/enc_bank.sv
// Bank of independent quadrature encoder channels; per-channel results are
// packed into flat output vectors, channel i at [i*CNT_W +: CNT_W].
module enc_bank #(
    parameter int NUM_CH     = 3,
    parameter int CNT_W      = 8,
    parameter int MAX        = 160,
    parameter int STEP_SHIFT = 0,
    parameter int WRAP       = 1,
    parameter int INIT       = 0,
    parameter int DEB_CYCLES = 50000,
    parameter int BTN_CLEAR  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic [NUM_CH-1:0]       enc_btn,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       changed,
    output logic [NUM_CH-1:0]       dir,
    output logic [NUM_CH-1:0]       btn_press
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        enc_channel #(
            .CNT_W      (CNT_W),
            .MAX        (MAX),
            .STEP_SHIFT (STEP_SHIFT),
            .WRAP       (WRAP),
            .INIT       (INIT),
            .DEB_CYCLES (DEB_CYCLES),
            .BTN_CLEAR  (BTN_CLEAR)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enc_a     (enc_a[gi]),
            .enc_b     (enc_b[gi]),
            .enc_btn   (enc_btn[gi]),
            .count     (count[gi*CNT_W +: CNT_W]),
            .changed   (changed[gi]),
            .dir       (dir[gi]),
            .btn_press (btn_press[gi])
        );
    end

endmodule

// File: tb/tb_enc_bank.sv
// Bench for enc_bank: three instances (main wrap, saturating, step-2 full range)
// driven by detent-level operations and checked against a transaction model.
module tb_enc_bank;

    localparam int HOLD   = 10;
    localparam int SETTLE = 3;
    localparam int OP_DET = 0, OP_BTN = 1, OP_GLITCH = 2, OP_ILL = 3, OP_PART = 4, OP_BTNDET = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [2:0]  a_pin [3];
    logic [2:0]  b_pin [3];
    logic [2:0]  btn_pin [3];
    logic [23:0] count0;
    logic [2:0]  changed0, dir0, bp0;
    logic [7:0]  count1, count2;
    logic        changed1, dir1, bp1, changed2, dir2, bp2;

    enc_bank #(.NUM_CH(3), .CNT_W(8), .MAX(160), .STEP_SHIFT(0), .WRAP(1), .INIT(0),
               .DEB_CYCLES(4), .BTN_CLEAR(1)) u_main (
        .clk(clk), .rst(rst), .enc_a(a_pin[0]), .enc_b(b_pin[0]), .enc_btn(btn_pin[0]),
        .count(count0), .changed(changed0), .dir(dir0), .btn_press(bp0));

    enc_bank #(.NUM_CH(1), .CNT_W(8), .MAX(160), .STEP_SHIFT(0), .WRAP(0), .INIT(0),
               .DEB_CYCLES(4), .BTN_CLEAR(1)) u_sat (
        .clk(clk), .rst(rst), .enc_a(a_pin[1][0]), .enc_b(b_pin[1][0]), .enc_btn(btn_pin[1][0]),
        .count(count1), .changed(changed1), .dir(dir1), .btn_press(bp1));

    enc_bank #(.NUM_CH(1), .CNT_W(8), .MAX(256), .STEP_SHIFT(1), .WRAP(1), .INIT(254),
               .DEB_CYCLES(4), .BTN_CLEAR(1)) u_step (
        .clk(clk), .rst(rst), .enc_a(a_pin[2][0]), .enc_b(b_pin[2][0]), .enc_btn(btn_pin[2][0]),
        .count(count2), .changed(changed2), .dir(dir2), .btn_press(bp2));

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt [3][3];
    int m_dir [3][3];
    int chg_n [3][3];
    int bp_n  [3][3];
    logic [1:0] cur_ph [3][3];
    logic       cur_btn [3][3];

    function automatic int nch(input int d);  return (d == 0) ? 3 : 1;     endfunction
    function automatic int max_of(input int d);  return (d == 2) ? 256 : 160; endfunction
    function automatic int step_of(input int d); return (d == 2) ? 2 : 1;     endfunction
    function automatic int wrap_of(input int d); return (d == 1) ? 0 : 1;     endfunction
    function automatic int init_of(input int d); return (d == 2) ? 254 : 0;   endfunction

    function automatic int get_cnt(input int d, input int c);
        case (d)
            0:       return int'(count0[c*8 +: 8]);
            1:       return int'(count1);
            default: return int'(count2);
        endcase
    endfunction
    function automatic int get_chg(input int d, input int c);
        case (d)
            0:       return int'(changed0[c]);
            1:       return int'(changed1);
            default: return int'(changed2);
        endcase
    endfunction
    function automatic int get_dir(input int d, input int c);
        case (d)
            0:       return int'(dir0[c]);
            1:       return int'(dir1);
            default: return int'(dir2);
        endcase
    endfunction
    function automatic int get_bp(input int d, input int c);
        case (d)
            0:       return int'(bp0[c]);
            1:       return int'(bp1);
            default: return int'(bp2);
        endcase
    endfunction

    // Position after one detent, straight from the wrap/saturate rules
    function automatic int ref_move(input int d, input int v, input logic cw);
        int s, m;
        s = step_of(d);
        m = max_of(d);
        if (cw) return (v + s < m) ? v + s : ((wrap_of(d) != 0) ? (v + s) % m : m - 1);
        return (v >= s) ? v - s : ((wrap_of(d) != 0) ? (v - s + m) % m : 0);
    endfunction

    function automatic logic [1:0] seq_ph(input logic cw, input int k);
        logic [7:0] cw_seq, ccw_seq;
        cw_seq  = 8'b01_00_10_11;
        ccw_seq = 8'b10_00_01_11;
        return cw ? cw_seq[7-2*k -: 2] : ccw_seq[7-2*k -: 2];
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 3; d++)
                for (int c = 0; c < nch(d); c++) begin
                    chg_n[d][c] += get_chg(d, c);
                    bp_n[d][c]  += get_bp(d, c);
                end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input int d);
        for (int c = 0; c < nch(d); c++) begin
            a_pin[d][c]   = cur_ph[d][c][1];
            b_pin[d][c]   = cur_ph[d][c][0];
            btn_pin[d][c] = cur_btn[d][c];
        end
    endtask

    task automatic check_dut(input int d, input int snap_c [3], input int snap_b [3],
                             input int e_c [3], input int e_b [3], input string tag);
        for (int c = 0; c < nch(d); c++) begin
            chk($sformatf("%s cnt d%0d c%0d", tag, d, c), get_cnt(d, c), m_cnt[d][c]);
            chk($sformatf("%s chg d%0d c%0d", tag, d, c), chg_n[d][c] - snap_c[c], e_c[c]);
            chk($sformatf("%s bp d%0d c%0d", tag, d, c), bp_n[d][c] - snap_b[c], e_b[c]);
            chk($sformatf("%s dir d%0d c%0d", tag, d, c), get_dir(d, c), m_dir[d][c]);
        end
    endtask

    task automatic run_op(input int d, input int op, input logic [2:0] mask, input logic [2:0] cwv);
        int snap_c [3], snap_b [3], e_c [3], e_b [3];
        int nv;
        for (int c = 0; c < 3; c++) begin
            snap_c[c] = chg_n[d][c];
            snap_b[c] = bp_n[d][c];
            e_c[c] = 0;
            e_b[c] = 0;
        end
        for (int c = 0; c < nch(d); c++) begin
            if (mask[c]) begin
                if (op == OP_DET) begin
                    nv = ref_move(d, m_cnt[d][c], cwv[c]);
                    e_c[c] = (nv != m_cnt[d][c]) ? 1 : 0;
                    m_cnt[d][c] = nv;
                    m_dir[d][c] = int'(cwv[c]);
                end else if (op == OP_BTN || op == OP_BTNDET) begin
                    e_b[c] = 1;
                    e_c[c] = (m_cnt[d][c] != init_of(d)) ? 1 : 0;
                    m_cnt[d][c] = init_of(d);
                end
            end
        end
        case (op)
            OP_DET, OP_BTNDET: begin
                for (int k = 0; k < 4; k++) begin
                    for (int c = 0; c < nch(d); c++) begin
                        if (mask[c]) begin
                            cur_ph[d][c] = seq_ph(cwv[c], k);
                            if (op == OP_BTNDET && k == 3) cur_btn[d][c] = 1'b1;
                        end
                    end
                    apply(d);
                    hold(HOLD);
                end
                if (op == OP_BTNDET) begin
                    for (int c = 0; c < nch(d); c++) cur_btn[d][c] = 1'b0;
                    apply(d);
                    hold(HOLD);
                end
            end
            OP_BTN: begin
                for (int c = 0; c < nch(d); c++) if (mask[c]) cur_btn[d][c] = 1'b1;
                apply(d);
                hold(HOLD);
                for (int c = 0; c < nch(d); c++) cur_btn[d][c] = 1'b0;
                apply(d);
                hold(HOLD);
            end
            OP_GLITCH: begin
                for (int c = 0; c < nch(d); c++) if (mask[c]) cur_ph[d][c] = 2'b01;
                apply(d);
                hold(2);
                for (int c = 0; c < nch(d); c++) cur_ph[d][c] = 2'b11;
                apply(d);
                hold(HOLD);
            end
            default: begin
                for (int c = 0; c < nch(d); c++)
                    if (mask[c]) cur_ph[d][c] = (op == OP_ILL) ? 2'b00 : 2'b01;
                apply(d);
                hold(HOLD);
                for (int c = 0; c < nch(d); c++) cur_ph[d][c] = 2'b11;
                apply(d);
                hold(HOLD);
            end
        endcase
        hold(SETTLE);
        check_dut(d, snap_c, snap_b, e_c, e_b, $sformatf("op%0d", op));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 3; c++) begin
                m_cnt[d][c] = init_of(d);
                m_dir[d][c] = 0;
            end
    endtask

    initial begin
        int snap_c [3], snap_b [3], zero [3];
        int tgt_dist;
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 3; c++) begin
                cur_ph[d][c]  = 2'b11;
                cur_btn[d][c] = 1'b0;
                chg_n[d][c]   = 0;
                bp_n[d][c]    = 0;
            end
        for (int c = 0; c < 3; c++) zero[c] = 0;
        for (int d = 0; d < 3; d++) apply(d);
        model_reset();
        rst = 1'b0;

        // Reset state, then 100 idle cycles with no pulses
        hold(3);
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < nch(d); c++) begin
                chk("rst cnt", get_cnt(d, c), init_of(d));
                chk("rst chg", get_chg(d, c), 0);
                chk("rst bp", get_bp(d, c), 0);
                chk("rst dir", get_dir(d, c), 0);
            end
        rst = 1'b1;
        hold(100);
        for (int d = 0; d < 3; d++) check_dut(d, zero, zero, zero, zero, "idle");

        // Cycle-exact CW detent on main ch0
        for (int k = 0; k < 3; k++) begin
            cur_ph[0][0] = seq_ph(1'b1, k);
            apply(0);
            hold(HOLD);
        end
        cur_ph[0][0] = 2'b11;
        apply(0);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) begin
                chk("lat pre cnt", get_cnt(0, 0), 0);
                chk("lat pre chg", int'(changed0), 0);
            end
        end
        chk("lat cnt", get_cnt(0, 0), 1);
        chk("lat chg", int'(changed0), 1);
        chk("lat dir", int'(dir0), 1);
        hold(1);
        chk("lat chg off", int'(changed0), 0);
        chk("lat cnt ch1", get_cnt(0, 1), 0);
        chk("lat cnt ch2", get_cnt(0, 2), 0);
        m_cnt[0][0] = 1;
        m_dir[0][0] = 1;
        hold(HOLD);

        // Wrap below zero on ch1, then bounce / illegal / partial moves
        run_op(0, OP_DET, 3'b010, 3'b000);
        run_op(0, OP_GLITCH, 3'b111, 3'b000);
        run_op(0, OP_ILL, 3'b111, 3'b000);
        run_op(0, OP_PART, 3'b111, 3'b000);

        // Saturating instance: clear keeps dir, saturated detent updates dir silently
        run_op(1, OP_DET, 3'b001, 3'b001);
        run_op(1, OP_BTN, 3'b001, 3'b000);
        run_op(1, OP_DET, 3'b001, 3'b000);
        for (int k = 0; k < 159; k++) run_op(1, OP_DET, 3'b001, 3'b001);
        run_op(1, OP_DET, 3'b001, 3'b001);

        // Step-2 full-range instance starting at 254
        run_op(2, OP_DET, 3'b001, 3'b001);
        run_op(2, OP_DET, 3'b001, 3'b001);
        run_op(2, OP_DET, 3'b001, 3'b000);
        run_op(2, OP_DET, 3'b001, 3'b000);

        // Randomised traffic on the main bank
        for (int n = 0; n < 40; n++) begin
            int op;
            op = int'($urandom_range(0, 6));
            if (op > OP_PART) op = OP_DET;
            run_op(0, op, 3'($urandom_range(1, 7)), 3'($urandom));
        end

        // Bring ch2 to 37, then button edge coincides with a CW detent
        while (m_cnt[0][2] != 37) begin
            tgt_dist = (37 - m_cnt[0][2] + 160) % 160;
            run_op(0, OP_DET, 3'b100, (tgt_dist < 80) ? 3'b100 : 3'b000);
        end
        run_op(0, OP_BTNDET, 3'b100, 3'b100);
        run_op(0, OP_DET, 3'b011, 3'b001);

        // Reset after two CW phases on ch2, then finish the rotation
        for (int c = 0; c < 3; c++) begin
            snap_c[c] = chg_n[0][c];
            snap_b[c] = bp_n[0][c];
        end
        for (int k = 0; k < 2; k++) begin
            cur_ph[0][2] = seq_ph(1'b1, k);
            apply(0);
            hold(HOLD);
        end
        rst = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("mid rst cnt", get_cnt(0, c), 0);
            chk("mid rst dir", get_dir(0, c), 0);
        end
        chk("mid rst chg", int'(changed0), 0);
        chk("mid rst bp", int'(bp0), 0);
        hold(3);
        rst = 1'b1;
        hold(HOLD);
        for (int k = 2; k < 4; k++) begin
            cur_ph[0][2] = seq_ph(1'b1, k);
            apply(0);
            hold(HOLD);
        end
        hold(100);
        check_dut(0, snap_c, snap_b, zero, zero, "post rst");
        chk("post rst cnt d1", get_cnt(1, 0), 0);
        chk("post rst cnt d2", get_cnt(2, 0), 254);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
